spi_grid: RTL and testbench
===========================

SPI_GRID -- requirements
Module: spi_grid

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; all logic on rising edge.
REQ-002 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: sck  in  1  SPI clock, asynchronous to clk, frequency at most clk/8.
REQ-004 SHALL have ports: mosi  in  1  SPI serial data in.
REQ-005 SHALL have ports: ss  in  1  SPI slave select, active-low.
REQ-006 SHALL have ports: miso  out  1  SPI serial data out.
REQ-007 SHALL have ports: trig  in  1  compute start request; level, asynchronous.
REQ-008 SHALL have ports: sign  in  1  accumulate polarity: 0 = add, 1 = subtract.
REQ-009 SHALL have parameters: ROWS, default 4, grid rows; COLS, default 4, grid columns; WW, default 8, weight width.

Function
REQ-010 SHALL synchronize sck, mosi, ss and trig into clk with 2-flop synchronizers, and detect edges on the synchronized copies.
REQ-011 SPI SHALL use mode 0, MSB first: sample mosi on a synchronized sck rising edge while ss=0, and shift miso on a sck falling edge.
REQ-012 Each ss-low period SHALL carry one byte; the byte SHALL complete on the 8th sck rising edge; further edges in the same ss-low period SHALL be ignored.
REQ-013 If ss rises before 8 bits arrive, the partial byte SHALL be discarded without changing the byte index.
REQ-014 Completed bytes SHALL form 3-byte transactions in order DATA, ADDR, CMD, tracked by a byte index 0..2 that wraps to 0 after CMD.
REQ-015 CMD 0x01 (write weight) SHALL store DATA into weight[ADDR[3:0]], where cell index = row*COLS + col; the write SHALL be ignored while busy.
REQ-016 CMD 0x02 (read weight) SHALL load weight[ADDR[3:0]] into the read register.
REQ-017 CMD 0x03 (read result low) SHALL load result[ADDR[1:0]][7:0] into the read register.
REQ-018 CMD 0x04 (read result high) SHALL load {4'b0, result[ADDR[1:0]][11:8]} into the read register.
REQ-019 CMD 0x05 (read status) SHALL load {6'b0, done, busy} into the read register.
REQ-020 Any other CMD SHALL be a no-op.
REQ-021 miso SHALL shift out the read register MSB first during the next ss-low frame; the MSB SHALL be valid from the ss falling edge.
REQ-022 miso SHALL be 0 while ss=1.
REQ-023 A synchronized trig rising edge while idle SHALL:
- latch sign;
- clear all results and done;
- set busy;
- start a time counter t=0.
REQ-024 A trig edge while busy SHALL be ignored.
REQ-025 While busy, on each clk, cell(r,c) SHALL pulse when t < weight[r][c]; result[r] (12-bit two's complement) SHALL add (latched sign=0) or subtract (sign=1) the count of pulsing cells in row r.
REQ-026 The phase SHALL last exactly 2^WW cycles (t = 0..255).
REQ-027 After the phase, busy SHALL clear and done SHALL set.
REQ-028 The final value of result[r] SHALL be ±(sum of row r weights), range -1020..+1020, with no overflow.
REQ-029 done SHALL stay set until the next trig or reset.
REQ-030 SPI transactions SHALL continue while busy; result reads during busy SHALL return intermediate values.

Reset
REQ-031 On rst=1 at a clk edge, the block SHALL clear: weights, results, busy, done, read register, byte index, bit counter and shift register.
REQ-032 miso SHALL read 0 after reset.
REQ-033 Reset mid-frame or mid-compute SHALL abort the operation; the next ss falling edge SHALL start a fresh byte 0.

Verification
REQ-034 Write DATA 0x2A, ADDR 0x05, CMD 0x01, then read with CMD 0x02 at ADDR 0x05 -> the following frame returns 0x2A on miso.
REQ-035 A frame with 9 sck rising edges -> only the first 8 bits are used; a frame with 5 bits then ss high -> discarded, and the next full byte is treated as DATA.
REQ-036 Set row 1 weights to 10, 20, 30, 40; sign=0; pulse trig -> status busy=1 during the phase; after 256+sync cycles done=1; result[1]=100 (low 0x64, high 0x00); other rows = 0.
REQ-037 Same weights with sign=1 -> result[1]=-100 (low 0x9C, high 0x0F).
REQ-038 All 16 weights = 0xFF, sign=0 -> each result = 1020 (low 0xFC, high 0x03).
REQ-039 A second trig during busy -> ignored; a weight write during busy -> ignored; rst asserted mid-compute -> status reads 0x00 and all results read 0.

Source files
------------

// File: rtl/spi_grid.sv
// SPI-controlled weight grid. Each row accumulates its count of pulsing cells while t < weight,
// so after 2^WW cycles every row result equals +/- the sum of that row's weights.
module spi_grid #(
  parameter int unsigned ROWS = 4,
  parameter int unsigned COLS = 4,
  parameter int unsigned WW   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic sck,
  input  logic mosi,
  input  logic ss,
  output logic miso,
  input  logic trig,
  input  logic sign
);
  localparam int unsigned NCELL = ROWS * COLS;
  localparam int unsigned CW    = (NCELL > 1) ? $clog2(NCELL) : 1;
  localparam int unsigned RIW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned RW    = 12;
  localparam int unsigned BW    = 8;

  typedef enum logic {ST_IDLE, ST_RUN} state_e;

  // Synchronizer chains: [0] meta, [1] sync, [2] previous sync for edge detect
  logic [2:0]     sck_sync_q, ss_sync_q, trig_sync_q;
  logic [1:0]     mosi_sync_q;
  logic           sck_rise_c, sck_fall_c, ss_rise_c, ss_fall_c, trig_rise_c, ss_c, mosi_c;

  state_e         state_q, state_d;
  logic           done_q, done_d;
  logic           sign_q, sign_d;
  logic [WW-1:0]  t_q, t_d;
  logic [RW-1:0]  result_q [ROWS];
  logic [RW-1:0]  result_d [ROWS];
  logic [WW-1:0]  weight_q [NCELL];
  logic [WW-1:0]  weight_d [NCELL];
  logic [BW-1:0]  rd_q, rd_d;
  logic [1:0]     idx_q, idx_d;
  logic [3:0]     bit_cnt_q, bit_cnt_d;
  logic [BW-2:0]  shift_q, shift_d;
  logic [BW-1:0]  tx_q, tx_d;
  logic [BW-1:0]  data_q, data_d;
  logic [3:0]     addr_q, addr_d;
  logic           frame_q, frame_d;
  logic           miso_q, miso_d;

  logic [BW-1:0]  byte_c;
  logic [CW-1:0]  cell_c;
  logic [RIW-1:0] row_c;
  logic           cell_ok_c, row_ok_c;
  logic [RW-1:0]  cnt_c;

  assign ss_c        = ss_sync_q[1];
  assign mosi_c      = mosi_sync_q[1];
  assign sck_rise_c  = sck_sync_q[1] & ~sck_sync_q[2];
  assign sck_fall_c  = ~sck_sync_q[1] & sck_sync_q[2];
  assign ss_rise_c   = ss_sync_q[1] & ~ss_sync_q[2];
  assign ss_fall_c   = ~ss_sync_q[1] & ss_sync_q[2];
  assign trig_rise_c = trig_sync_q[1] & ~trig_sync_q[2];

  assign byte_c    = {shift_q, mosi_c};
  assign cell_c    = CW'(addr_q);
  assign cell_ok_c = 32'(addr_q) < NCELL;
  assign row_c     = RIW'(addr_q[1:0]);
  assign row_ok_c  = 32'(addr_q[1:0]) < ROWS;
  assign miso      = miso_q;

  always_comb begin
    state_d   = state_q;
    done_d    = done_q;
    sign_d    = sign_q;
    t_d       = t_q;
    result_d  = result_q;
    weight_d  = weight_q;
    rd_d      = rd_q;
    idx_d     = idx_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    data_d    = data_q;
    addr_d    = addr_q;
    frame_d   = frame_q;
    miso_d    = ~ss_c & tx_q[BW-1];
    cnt_c     = '0;

    // A frame only counts if its ss falling edge was seen after reset
    if (ss_fall_c) begin
      frame_d   = 1'b1;
      bit_cnt_d = '0;
    end
    if (ss_rise_c) begin
      frame_d   = 1'b0;
      bit_cnt_d = '0;
    end

    if (frame_q && !ss_c && sck_rise_c && bit_cnt_q < 4'd8) begin
      shift_d   = byte_c[BW-2:0];
      bit_cnt_d = bit_cnt_q + 4'd1;
      if (bit_cnt_q == 4'd7) begin
        unique case (idx_q)
          2'd0: begin
            data_d = byte_c;
            idx_d  = 2'd1;
          end
          2'd1: begin
            addr_d = byte_c[3:0];
            idx_d  = 2'd2;
          end
          default: begin
            idx_d = 2'd0;
            unique case (byte_c)
              8'h01: if (state_q == ST_IDLE && cell_ok_c) weight_d[cell_c] = WW'(data_q);
              8'h02: rd_d = cell_ok_c ? BW'(weight_q[cell_c]) : '0;
              8'h03: rd_d = row_ok_c ? result_q[row_c][7:0] : '0;
              8'h04: rd_d = row_ok_c ? {4'b0, result_q[row_c][11:8]} : '0;
              8'h05: rd_d = {6'b0, done_q, state_q == ST_RUN};
              default: ;
            endcase
          end
        endcase
      end
    end

    // Reload the transmit shifter while deselected so MSB is ready at ss fall
    if (ss_c) begin
      tx_d = rd_q;
    end else if (frame_q && sck_fall_c) begin
      tx_d = {tx_q[BW-2:0], 1'b0};
    end

    unique case (state_q)
      ST_IDLE: begin
        if (trig_rise_c) begin
          state_d = ST_RUN;
          sign_d  = sign;
          done_d  = 1'b0;
          t_d     = '0;
          for (int unsigned r = 0; r < ROWS; r++) result_d[r] = '0;
        end
      end
      ST_RUN: begin
        for (int unsigned r = 0; r < ROWS; r++) begin
          cnt_c = '0;
          for (int unsigned c = 0; c < COLS; c++) begin
            if (t_q < weight_q[r*COLS + c]) cnt_c = cnt_c + RW'(1);
          end
          result_d[r] = sign_q ? result_q[r] - cnt_c : result_q[r] + cnt_c;
        end
        t_d = t_q + WW'(1);
        if (t_q == '1) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync_q  <= '0;
      ss_sync_q   <= '1;
      trig_sync_q <= '0;
      mosi_sync_q <= '0;
      state_q     <= ST_IDLE;
      done_q      <= 1'b0;
      sign_q      <= 1'b0;
      t_q         <= '0;
      result_q    <= '{default: '0};
      weight_q    <= '{default: '0};
      rd_q        <= '0;
      idx_q       <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      tx_q        <= '0;
      data_q      <= '0;
      addr_q      <= '0;
      frame_q     <= 1'b0;
      miso_q      <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[1:0], sck};
      ss_sync_q   <= {ss_sync_q[1:0], ss};
      trig_sync_q <= {trig_sync_q[1:0], trig};
      mosi_sync_q <= {mosi_sync_q[0], mosi};
      state_q     <= state_d;
      done_q      <= done_d;
      sign_q      <= sign_d;
      t_q         <= t_d;
      result_q    <= result_d;
      weight_q    <= weight_d;
      rd_q        <= rd_d;
      idx_q       <= idx_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      data_q      <= data_d;
      addr_q      <= addr_d;
      frame_q     <= frame_d;
      miso_q      <= miso_d;
    end
  end

endmodule

// File: tb/tb_spi_grid.sv
// Scoreboard bench for spi_grid: the driver predicts each frame's miso byte from a
// transaction-level model; an independent monitor captures frames and compares.
module tb_spi_grid;
  localparam int H = 6;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic sck  = 1'b0;
  logic mosi = 1'b0;
  logic ss   = 1'b1;
  logic trig = 1'b0;
  logic sign = 1'b0;
  logic miso;

  int vectors     = 0;
  int miscompares = 0;

  spi_grid dut (
    .clk (clk),
    .rst (rst),
    .sck (sck),
    .mosi(mosi),
    .ss  (ss),
    .miso(miso),
    .trig(trig),
    .sign(sign)
  );

  always #5 clk = ~clk;

  // Expected miso byte per frame; chk=0 frames carry nothing of interest
  bit         chk_q [$];
  logic [7:0] val_q [$];
  string      name_q[$];

  // Transaction-level reference model
  logic [7:0] m_w [16];
  int         m_res [4];
  bit         m_busy, m_done, m_sign;
  int         m_idx;
  logic [7:0] m_data, m_addr;
  bit         pend_chk;
  logic [7:0] pend_val;
  string      pend_name;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    end
  endtask

  function automatic void set_pend(input logic [7:0] v, input string n);
    pend_chk  = 1'b1;
    pend_val  = v;
    pend_name = n;
  endfunction

  function automatic logic [7:0] res_byte(input int r, input bit hi);
    logic [11:0] v;
    v = 12'(m_res[r]);
    return hi ? {4'h0, v[11:8]} : v[7:0];
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) m_w[i] = 8'h00;
    for (int r = 0; r < 4; r++) m_res[r] = 0;
    m_busy = 1'b0;
    m_done = 1'b0;
    m_sign = 1'b0;
    m_idx  = 0;
    m_data = 8'h00;
    m_addr = 8'h00;
    set_pend(8'h00, "after_reset");
  endfunction

  function automatic void model_trig();
    if (!m_busy) begin
      m_busy = 1'b1;
      m_done = 1'b0;
      m_sign = sign;
      for (int r = 0; r < 4; r++) m_res[r] = 0;
    end
  endfunction

  // Final row result is simply +/- the row's weight sum
  function automatic void model_finish();
    int sum;
    if (m_busy) begin
      for (int r = 0; r < 4; r++) begin
        sum = 0;
        for (int c = 0; c < 4; c++) sum += int'(m_w[r*4 + c]);
        m_res[r] = m_sign ? -sum : sum;
      end
      m_busy = 1'b0;
      m_done = 1'b1;
    end
  endfunction

  function automatic void apply_byte(input logic [7:0] b);
    if (m_idx == 0) m_data = b;
    else if (m_idx == 1) m_addr = b;
    else begin
      case (b)
        8'h01: if (!m_busy) m_w[m_addr[3:0]] = m_data;
        8'h02: set_pend(m_w[m_addr[3:0]], $sformatf("weight%0d", m_addr[3:0]));
        8'h03: set_pend(res_byte(int'(m_addr[1:0]), 1'b0), $sformatf("result%0d_lo", m_addr[1:0]));
        8'h04: set_pend(res_byte(int'(m_addr[1:0]), 1'b1), $sformatf("result%0d_hi", m_addr[1:0]));
        8'h05: set_pend({6'b0, m_done, m_busy}, "status");
        default: ;
      endcase
    end
    m_idx = (m_idx + 1) % 3;
  endfunction

  task automatic spi_frame(input logic [7:0] b, input int nbits);
    if (nbits >= 8) begin
      chk_q.push_back(pend_chk);
      val_q.push_back(pend_val);
      name_q.push_back(pend_name);
      pend_chk = 1'b0;
    end else begin
      chk_q.push_back(1'b0);
      val_q.push_back(8'h00);
      name_q.push_back("partial");
    end
    @(negedge clk) ss = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      mosi = (i < 8) ? b[3'(7 - i)] : 1'($urandom);
      repeat (H) @(negedge clk);
      sck = 1'b1;
      repeat (H) @(negedge clk);
      sck = 1'b0;
    end
    repeat (H) @(negedge clk);
    ss = 1'b1;
    repeat (8) @(negedge clk);
    check8("miso_idle", {7'b0, miso}, 8'h00);
    if (nbits >= 8) apply_byte(b);
  endtask

  task automatic txn(input logic [7:0] d, input logic [7:0] a, input logic [7:0] c);
    spi_frame(d, 8);
    spi_frame(a, 8);
    spi_frame(c, 8);
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] c);
    txn(8'($urandom), a, c);
  endtask

  task automatic pulse_trig();
    @(negedge clk) trig = 1'b1;
    model_trig();
    repeat (6) @(negedge clk);
    trig = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic wait_phase();
    repeat (300) @(negedge clk);
    model_finish();
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
  endtask

  task automatic read_all_results();
    for (int r = 0; r < 4; r++) begin
      rd(8'(r), 8'h03);
      rd(8'(r), 8'h04);
    end
  endtask

  // Monitor: captures the first 8 miso bits of every frame and scores it
  initial begin : monitor
    logic [7:0] cap;
    int         n;
    bit         c;
    logic [7:0] v;
    string      nm;
    forever begin
      @(negedge ss);
      cap = 8'h00;
      n   = 0;
      while (ss == 1'b0) begin
        @(posedge sck or posedge ss);
        if (ss == 1'b0) begin
          if (n < 8) cap = {cap[6:0], miso};
          n++;
        end
      end
      if (chk_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL sb_underflow: got frame 0x%02h, expected no frame", cap);
      end else begin
        c  = chk_q.pop_front();
        v  = val_q.pop_front();
        nm = name_q.pop_front();
        if (c) check8(nm, cap, v);
      end
    end
  end

  initial begin : driver
    model_reset();
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check8("miso_reset", {7'b0, miso}, 8'h00);

    // Basic write then readback
    txn(8'h2A, 8'h05, 8'h01);
    rd(8'h05, 8'h02);

    // 9-edge DATA frame, then a discarded 5-bit frame
    spi_frame(8'h3C, 9);
    spi_frame(8'h06, 8);
    spi_frame(8'h01, 8);
    rd(8'h06, 8'h02);
    spi_frame(8'hFF, 5);
    txn(8'h5C, 8'h03, 8'h01);
    rd(8'h03, 8'h02);

    // Random transactions of every command kind
    for (int i = 0; i < 20; i++) txn(8'($urandom), 8'($urandom), 8'($urandom_range(0, 7)));

    // Random weights, random polarity compute
    for (int i = 0; i < 16; i++) txn(8'($urandom), 8'(i), 8'h01);
    sign = 1'($urandom);
    pulse_trig();
    wait_phase();
    read_all_results();
    for (int i = 0; i < 4; i++) rd(8'($urandom_range(0, 15)), 8'h02);

    // Row 1 = 10,20,30,40 added, status sampled mid-phase
    do_reset();
    txn(8'd10, 8'd4, 8'h01);
    txn(8'd20, 8'd5, 8'h01);
    txn(8'd30, 8'd6, 8'h01);
    txn(8'd40, 8'd7, 8'h01);
    sign = 1'b0;
    spi_frame(8'h00, 8);
    spi_frame(8'h00, 8);
    pulse_trig();
    spi_frame(8'h05, 8);
    wait_phase();
    rd(8'h00, 8'h05);
    read_all_results();

    // Same weights subtracted
    sign = 1'b1;
    pulse_trig();
    wait_phase();
    rd(8'h01, 8'h03);
    rd(8'h01, 8'h04);
    rd(8'h00, 8'h03);

    // Full-scale weights
    for (int i = 0; i < 16; i++) txn(8'hFF, 8'(i), 8'h01);
    sign = 1'b0;
    pulse_trig();
    wait_phase();
    read_all_results();

    // Second trig mid-phase must not restart the computation
    sign = 1'b1;
    spi_frame(8'h00, 8);
    spi_frame(8'h00, 8);
    pulse_trig();
    repeat (90) @(negedge clk);
    pulse_trig();
    repeat (90) @(negedge clk);
    model_finish();
    spi_frame(8'h05, 8);
    rd(8'h02, 8'h03);
    rd(8'h02, 8'h04);

    // Weight write during busy is dropped
    sign = 1'b0;
    spi_frame(8'h77, 8);
    spi_frame(8'h05, 8);
    pulse_trig();
    spi_frame(8'h01, 8);
    wait_phase();
    rd(8'h05, 8'h02);

    // Reset mid-compute clears status, results and weights
    pulse_trig();
    repeat (40) @(negedge clk);
    do_reset();
    check8("miso_after_rst", {7'b0, miso}, 8'h00);
    rd(8'h00, 8'h05);
    read_all_results();
    rd(8'h0A, 8'h02);

    spi_frame(8'h00, 8);
    repeat (20) @(negedge clk);
    check8("sb_drain", 8'(chk_q.size()), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
